// File: rtl/branch_history_predictor.sv
// ---------------------------------------------------------------------------
// branch_history_predictor
//
// Table of saturating counters that predicts whether a conditional branch is
// taken. The table can be indexed by PC bits alone (bimodal), or by PC bits
// XORed with a short global taken/not-taken history (gshare style).
//
// Parameters
//   PC_W    width of the program-counter inputs (must exceed IDX_W)
//   IDX_W   table index width; the table holds 2**IDX_W counters
//   CNT_W   saturating-counter width, 1..4
//   HIST_W  global-history width, 0..IDX_W; 0 means pure bimodal indexing
//   INIT    value loaded into every counter on reset
//
// Ports
//   clk          single clock; all state updates on its rising edge
//   rst          asynchronous, active-high reset
//   stall        freezes counters and history while high
//   lookup_pc    PC of the branch being predicted this cycle
//   take_branch  prediction for lookup_pc (1 = taken), combinational
//   upd_pc       PC of the branch being resolved this cycle
//   taken        resolved branch at upd_pc was taken
//   not_taken    resolved branch at upd_pc was not taken
//
// Update handshake: an update is accepted when exactly one of taken /
// not_taken is high and stall is low. It is applied at the next rising edge
// and there is no ready/backpressure. Both flags high together is illegal
// and is ignored.
// ---------------------------------------------------------------------------
module branch_history_predictor #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 0,
    parameter int INIT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            take_branch,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            taken,
    input  logic            not_taken
);

    localparam int              ENTRIES  = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);

    logic [CNT_W-1:0] r_cnt [ENTRIES];

    logic             w_upd_valid;
    logic [IDX_W-1:0] w_hist_ext;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_next;

    // Bit 0 of the PCs is never used for indexing, and neither are the bits
    // above IDX_W. This reduction only keeps lint quiet about them.
    logic w_unused;
    assign w_unused = &{1'b0, lookup_pc, upd_pc};

    // XOR of taken and not_taken rejects the illegal both-high case.
    assign w_upd_valid = (taken ^ not_taken) & ~stall;

    // The global history register exists only when HIST_W > 0. It is
    // zero-extended on the left to the index width before the XOR.
    generate
        if (HIST_W > 0) begin : g_ghr
            logic [HIST_W-1:0] r_ghr;

            // Shift instead of a part-select, so HIST_W == 1 stays legal.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (w_upd_valid) begin
                    r_ghr <= (r_ghr << 1) | HIST_W'(taken);
                end
            end

            assign w_hist_ext = IDX_W'(r_ghr);
        end else begin : g_no_ghr
            assign w_hist_ext = '0;
        end
    endgenerate

    // Bit 1 is kept, so 16-bit compressed branches get distinct entries.
    assign w_lookup_idx = lookup_pc[IDX_W:1] ^ w_hist_ext;
    assign w_upd_idx    = upd_pc[IDX_W:1]    ^ w_hist_ext;

    // The prediction reads registered state only. A same-cycle update to the
    // same entry is not bypassed.
    assign take_branch = r_cnt[w_lookup_idx][CNT_W-1];

    assign w_cnt_cur = r_cnt[w_upd_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (taken && (w_cnt_cur != CNT_MAX)) begin
            w_cnt_next = w_cnt_cur + 1'b1;
        end else if (not_taken && (w_cnt_cur != '0)) begin
            w_cnt_next = w_cnt_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= CNT_INIT;
            end
        end else if (w_upd_valid) begin
            r_cnt[w_upd_idx] <= w_cnt_next;
        end
    end

endmodule

// File: doc/branch_history_predictor.md
BRANCH_HISTORY_PREDICTOR -- requirements
Module: branch_history_predictor

Interface
REQ-001 Parameter PC_W, default 32, width of program-counter inputs.
REQ-002 Parameter IDX_W, default 4, table index width; ENTRIES = 2**IDX_W counters.
REQ-003 Parameter CNT_W, default 2, saturating-counter width; legal range 1..4.
REQ-004 Parameter HIST_W, default 0, global-history width; legal range 0..IDX_W; 0 selects pure bimodal indexing.
REQ-005 Parameter INIT, default 0, reset value loaded into every counter; legal range 0..2**CNT_W-1.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 stall  input  1  freezes all state (counters and history) while high.
REQ-009 lookup_pc  input  PC_W  PC of the branch being predicted this cycle.
REQ-010 take_branch  output  1  prediction for lookup_pc; 1 = taken.
REQ-011 upd_pc  input  PC_W  PC of the branch being resolved this cycle.
REQ-012 taken  input  1  resolved branch at upd_pc was taken.
REQ-013 not_taken  input  1  resolved branch at upd_pc was not taken.

Function
REQ-014 State: ENTRIES counters of CNT_W bits each, plus a HIST_W-bit global history register ghr (absent when HIST_W = 0).
REQ-015 Index function: idx(pc) = pc[IDX_W:1] XOR {IDX_W-HIST_W zeros, ghr}; bit 0 is dropped, bit 1 is kept so compressed 16-bit branches map distinctly.
REQ-016 take_branch is combinational: MSB of counter[idx(lookup_pc)], computed from current registered state; zero-cycle latency.
REQ-017 Update: a valid update is exactly one of taken/not_taken high with stall low; it is applied at the next posedge to counter[idx(upd_pc)], idx using the pre-update ghr.
REQ-018 taken: counter increments by 1, saturating at 2**CNT_W-1 (no wrap).
REQ-019 not_taken: counter decrements by 1, saturating at 0 (no wrap).
REQ-020 With CNT_W = 2 the encodings are 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-021 On a valid update ghr shifts left by one, inserting 1 for taken and 0 for not_taken at bit 0; the oldest bit is discarded.
REQ-022 taken and not_taken both high in one cycle is illegal; the block treats it as no update (counters and ghr unchanged).
REQ-023 Neither taken nor not_taken high: no state change.
REQ-024 stall high: no state change regardless of taken/not_taken; take_branch still reflects current state.
REQ-025 Lookup and update to the same index in one cycle: take_branch reports the pre-update value; the new value is visible from the following cycle (no bypass).
REQ-026 Only the addressed counter changes on an update; all other entries are unchanged.

Reset
REQ-027 rst high asynchronously sets every counter to INIT and ghr to 0, without waiting for a clock edge.
REQ-028 While rst is high, take_branch equals INIT[CNT_W-1] for every lookup_pc.
REQ-029 rst asserted mid-update discards the pending update; after deassertion the first posedge applies normal update rules.

Verification
REQ-030 Defaults, reset, then 3 taken updates on upd_pc=0x10 -> counter at idx 8 goes 00,01,10,11; take_branch for lookup_pc=0x10 becomes 1 after the 2nd update; a 4th taken keeps 11.
REQ-031 Defaults, counter at 11, 4 not_taken on 0x10 -> 10,01,00,00; take_branch falls to 0 after the 2nd update; counter at idx(0x12)=9 stays 00 throughout.
REQ-032 stall=1 with taken=1 for 5 cycles on 0x10 -> counter and ghr unchanged; stall=0 for one taken cycle -> counter +1.
REQ-033 taken=not_taken=1 on 0x10 for 3 cycles -> no state change; concurrent lookup of 0x10 with a taken update returns the old prediction that cycle and the new one next cycle.
REQ-034 HIST_W=2, IDX_W=4: updates taken, not_taken -> ghr=2'b10; a subsequent update on upd_pc=0x10 modifies idx 8 XOR 2 = 10, and lookup_pc=0x10 reads idx 10.
REQ-035 INIT=1, rst pulsed asynchronously between clock edges during a taken stream -> all counters read 01 and ghr reads 0 immediately; take_branch=0 for all PCs until updated.
